// File: rtl/huffman_pkg.sv
// Shared Huffman encoder/decoder definitions: FSM states, table entry layout and defaults.
package huffman_pkg;

  localparam int unsigned W_DEF = 8;
  localparam int unsigned N_DEF = 16;
  localparam int unsigned CNT_W = $clog2(2 * W_DEF + 1);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    CONF  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [W_DEF-1:0] sym;
    logic [W_DEF-1:0] code;
    logic [CNT_W-1:0] width;
  } entry_t;

endpackage

// File: rtl/huffman_enc_lut.sv
// Runtime-loaded code table: write pointer, valid bits and lowest-index associative match.
module huffman_enc_lut
  import huffman_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned N  = N_DEF,
  parameter int unsigned WW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_conf,
  input  logic          en_conf,
  input  logic [W-1:0]  d_conf,
  input  logic [W-1:0]  h_conf,
  input  logic [W-1:0]  w_conf,
  input  logic [W-1:0]  s_in,
  output logic          hit,
  output logic [W-1:0]  code,
  output logic [WW-1:0] width,
  output logic          wr_err
);

  localparam int unsigned PW = $clog2(N + 1);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [PW-1:0] N_LIM = PW'(N);
  localparam logic [W-1:0]  W_LIM = W[W-1:0];

  logic [N-1:0]  valid;
  logic [W-1:0]  sym_mem  [N];
  logic [W-1:0]  code_mem [N];
  logic [WW-1:0] wid_mem  [N];
  logic [PW-1:0] ptr;
  logic          full, bad_w, wr_ok;
  logic [IW-1:0] idx;

  assign full   = (ptr == N_LIM);
  assign bad_w  = (w_conf == '0) || (w_conf > W_LIM);
  assign wr_ok  = en_conf & ~new_conf & ~full & ~bad_w;
  assign wr_err = en_conf & ~new_conf & (full | bad_w);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      ptr   <= '0;
    end else if (new_conf) begin
      valid <= '0;
      ptr   <= '0;
    end else if (wr_ok) begin
      valid[ptr[IW-1:0]] <= 1'b1;
      ptr                <= ptr + 1'b1;
    end
  end

  // Code bits above the width are masked so the packer's padding stays zero.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      sym_mem[ptr[IW-1:0]]  <= d_conf;
      code_mem[ptr[IW-1:0]] <= h_conf & ~({W{1'b1}} << w_conf);
      wid_mem[ptr[IW-1:0]]  <= w_conf[WW-1:0];
    end
  end

  always_comb begin
    hit   = 1'b0;
    code  = '0;
    width = '0;
    idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'(N - 1 - i);
      if (valid[idx] && (sym_mem[idx] == s_in)) begin
        hit   = 1'b1;
        code  = code_mem[idx];
        width = wid_mem[idx];
      end
    end
  end

endmodule

// File: rtl/huffman_enc.sv
// Huffman encoder top: symbol lookup, MSB-first packer and RUN/CONF/FLUSH control.
// Optional HUFF_ENC_STATS_EN adds sym_cnt/word_cnt statistics outputs.
module huffman_enc
  import huffman_pkg::*;
#(
  parameter int unsigned W = W_DEF,
  parameter int unsigned N = N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_in,
  input  logic         s_en,
  output logic         s_req,
  input  logic         flush,
  input  logic [W-1:0] d_conf,
  input  logic [W-1:0] h_conf,
  input  logic [W-1:0] w_conf,
  input  logic         en_conf,
  input  logic         new_conf,
  input  logic         d_req,
  output logic [W-1:0] d_out,
  output logic         en_out,
  output logic         err
`ifdef HUFF_ENC_STATS_EN
  ,
  output logic [15:0]  sym_cnt,
  output logic [15:0]  word_cnt
`endif
);

  localparam int unsigned CW = $clog2(2 * W + 1);
  localparam int unsigned WW = $clog2(W + 1);
  localparam logic [CW-1:0] W_C  = CW'(W);
  localparam logic [CW-1:0] TW_C = CW'(2 * W);

  state_t          state, state_nxt;
  logic [2*W-1:0]  acc, acc_x, acc_nxt, ins;
  logic [CW-1:0]   cnt, cnt_x, cnt_nxt, w_ext;
  logic            rdy, err_q;
  logic            hit, wr_err, accept, xfer;
  logic [W-1:0]    code;
  logic [WW-1:0]   width;

  huffman_enc_lut #(.W(W), .N(N), .WW(WW)) u_lut (
    .clk      (clk),
    .rst      (rst),
    .new_conf (new_conf),
    .en_conf  (en_conf),
    .d_conf   (d_conf),
    .h_conf   (h_conf),
    .w_conf   (w_conf),
    .s_in     (s_in),
    .hit      (hit),
    .code     (code),
    .width    (width),
    .wr_err   (wr_err)
  );

  // rdy keeps s_req low during reset and for the first cycle after release.
  assign s_req  = rdy & (state == RUN) & (cnt <= W_C) & ~en_conf & ~new_conf;
  assign en_out = (cnt >= W_C) | ((state == FLUSH) & (cnt != '0));
  assign d_out  = acc[2*W-1 -: W];
  assign err    = err_q;
  assign xfer   = en_out & d_req;
  assign accept = s_req & s_en;
  assign w_ext  = CW'(width);

  // Extraction is applied first so insertion lands right after the surviving bits.
  always_comb begin
    acc_x = acc;
    cnt_x = cnt;
    if (xfer) begin
      acc_x = acc << W;
      cnt_x = (cnt >= W_C) ? cnt - W_C : '0;
    end
    ins     = {{W{1'b0}}, code} << (TW_C - cnt_x - w_ext);
    acc_nxt = acc_x;
    cnt_nxt = cnt_x;
    if (accept && hit) begin
      acc_nxt = acc_x | ins;
      cnt_nxt = cnt_x + w_ext;
    end
  end

  always_comb begin
    state_nxt = state;
    if (new_conf || en_conf) begin
      state_nxt = CONF;
    end else begin
      case (state)
        CONF:    state_nxt = RUN;
        RUN:     if (flush) state_nxt = FLUSH;
        FLUSH:   if (cnt_x == '0) state_nxt = RUN;
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      acc   <= '0;
      cnt   <= '0;
      rdy   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      rdy   <= 1'b1;
      state <= state_nxt;
      if (new_conf) begin
        acc   <= '0;
        cnt   <= '0;
        err_q <= 1'b0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        if (wr_err || (accept && !hit)) err_q <= 1'b1;
      end
    end
  end

`ifdef HUFF_ENC_STATS_EN
  logic [15:0] sym_q, word_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_q  <= '0;
      word_q <= '0;
    end else if (new_conf) begin
      sym_q  <= '0;
      word_q <= '0;
    end else begin
      if (accept && hit) sym_q <= sym_q + 16'd1;
      if (xfer) word_q <= word_q + 16'd1;
    end
  end

  assign sym_cnt  = sym_q;
  assign word_cnt = word_q;
`endif

endmodule

// File: tb/tb_huffman_enc.sv
// Self-checking bench for huffman_enc: directed vector table, hand-written corner
// sequences and randomized traffic against a bit-queue reference model.
module tb_huffman_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s_in, d_conf, h_conf, w_conf, d_out;
  logic       s_en, s_req, flush, en_conf, new_conf, d_req, en_out, err;
`ifdef HUFF_ENC_STATS_EN
  logic [15:0] sym_cnt, word_cnt;
`endif

  always #5 clk = ~clk;

  huffman_enc #(.W(8), .N(16)) dut (
    .clk(clk), .rst(rst), .s_in(s_in), .s_en(s_en), .s_req(s_req), .flush(flush),
    .d_conf(d_conf), .h_conf(h_conf), .w_conf(w_conf), .en_conf(en_conf),
    .new_conf(new_conf), .d_req(d_req), .d_out(d_out), .en_out(en_out), .err(err)
`ifdef HUFF_ENC_STATS_EN
    , .sym_cnt(sym_cnt), .word_cnt(word_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pending code bits in order, table as an ordered entry list.
  bit         q[$];
  logic [7:0] m_sym[$];
  logic [7:0] m_code[$];
  int         m_w[$];
  bit         m_err, m_flush, m_conf, m_rdy;
  logic [7:0] got[$];
  bit         acc_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); m_sym.delete(); m_code.delete(); m_w.delete();
    m_err = 0; m_flush = 0; m_conf = 0; m_rdy = 0;
  endtask

  task automatic cycle();
    bit exp_sreq, exp_en;
    logic [7:0] word;
    int hitidx;
    #1;
    exp_sreq = m_rdy && !m_conf && !en_conf && !new_conf && !m_flush && (q.size() <= 8);
    exp_en   = (q.size() >= 8) || (m_flush && q.size() > 0);
    check("s_req", s_req, exp_sreq);
    check("en_out", en_out, exp_en);
    check("err", err, m_err);
    acc_last = 0;
    if (new_conf) begin
      q.delete(); m_sym.delete(); m_code.delete(); m_w.delete();
      m_err = 0; m_flush = 0;
    end else begin
      if (exp_en && d_req) begin
        word = '0;
        for (int i = 0; i < 8; i++) if (q.size() > 0) word[7-i] = q.pop_front();
        check("d_out", d_out, word);
        got.push_back(d_out);
      end
      if (exp_sreq && s_en) begin
        acc_last = 1;
        hitidx = -1;
        for (int i = 0; i < m_sym.size(); i++) if (hitidx < 0 && m_sym[i] == s_in) hitidx = i;
        if (hitidx < 0) m_err = 1;
        else for (int b = m_w[hitidx] - 1; b >= 0; b--) q.push_back(m_code[hitidx][b]);
      end
      if (en_conf) begin
        if (m_sym.size() == 16) m_err = 1;
        else if (w_conf == 0 || w_conf > 8) m_err = 1;
        else begin
          m_sym.push_back(d_conf); m_code.push_back(h_conf); m_w.push_back(int'(w_conf));
        end
      end
      if (en_conf) m_flush = 0;
      else if (m_flush) begin
        if (q.size() == 0) m_flush = 0;
      end else if (!m_conf && flush) m_flush = 1;
    end
    m_conf = en_conf || new_conf;
    m_rdy  = 1;
    @(posedge clk); #1;
  endtask

  task automatic conf_new();
    new_conf = 1; cycle(); new_conf = 0;
  endtask

  task automatic conf_wr(input logic [7:0] sym, input logic [7:0] code, input logic [7:0] w);
    d_conf = sym; h_conf = code; w_conf = w; en_conf = 1; cycle(); en_conf = 0;
  endtask

  task automatic send(input logic [7:0] sym);
    int t = 0;
    s_in = sym; s_en = 1;
    do begin cycle(); t++; end while (!acc_last && t < 200);
    s_en = 0;
    if (!acc_last) begin
      tests++; fails++;
      $display("FAIL send_timeout: symbol %0h not accepted within 200 cycles", sym);
    end
  endtask

  task automatic flush_drain();
    int t = 0;
    d_req = 1; flush = 1; cycle(); flush = 0;
    while ((m_flush || q.size() > 0) && t < 60) begin cycle(); t++; end
    check("drain_idle", en_out, 0);
  endtask

  typedef struct {
    string      name;
    logic [7:0] s0, c0, w0, s1, c1, w1;
    int         nsym;
    int         nw;
    logic [7:0] words [4];
    bit         do_flush;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int idx, t;
    logic [7:0] hold;

    vecs[0] = '{"two_bit",   8'h20, 8'h00, 8'd2, 8'h21, 8'h01, 8'd2, 4,  1, '{8'h11, 8'h00, 8'h00, 8'h00}, 1'b0};
    vecs[1] = '{"three_bit", 8'h30, 8'h04, 8'd3, 8'h31, 8'h05, 8'd3, 8,  3, '{8'h96, 8'h59, 8'h65, 8'h00}, 1'b0};
    vecs[2] = '{"flush",     8'h40, 8'h0C, 8'd4, 8'h41, 8'h0C, 8'd4, 1,  1, '{8'hC0, 8'h00, 8'h00, 8'h00}, 1'b1};
    vecs[3] = '{"one_bit",   8'h01, 8'h01, 8'd1, 8'h02, 8'h00, 8'd1, 10, 2, '{8'hAA, 8'h80, 8'h00, 8'h00}, 1'b1};
    vecs[4] = '{"eight_bit", 8'h55, 8'hA5, 8'd8, 8'h56, 8'h3C, 8'd8, 3,  3, '{8'hA5, 8'h3C, 8'hA5, 8'h00}, 1'b0};
    vecs[5] = '{"mask_code", 8'h60, 8'hFD, 8'd3, 8'h61, 8'hF2, 8'd2, 4,  2, '{8'hB5, 8'h80, 8'h00, 8'h00}, 1'b1};

    rst = 0; s_in = 0; s_en = 0; flush = 0; d_conf = 0; h_conf = 0; w_conf = 0;
    en_conf = 0; new_conf = 0; d_req = 0;
    model_reset();
    #12;
    check("rst_s_req", s_req, 0);
    check("rst_d_out", d_out, 0);
    check("rst_en_out", en_out, 0);
    check("rst_err", err, 0);
`ifdef HUFF_ENC_STATS_EN
    check("rst_sym_cnt", sym_cnt, 0);
    check("rst_word_cnt", word_cnt, 0);
`endif
    rst = 1;
    cycle();
    cycle();

    // Directed vector table
    foreach (vecs[v]) begin
      conf_new();
      conf_wr(vecs[v].s0, vecs[v].c0, vecs[v].w0);
      conf_wr(vecs[v].s1, vecs[v].c1, vecs[v].w1);
      cycle();
      got.delete();
      d_req = 1;
      for (int k = 0; k < vecs[v].nsym; k++) send((k % 2) ? vecs[v].s1 : vecs[v].s0);
      if (vecs[v].do_flush) flush_drain();
      else for (int k = 0; k < 4; k++) cycle();
      check({vecs[v].name, "_nwords"}, got.size(), vecs[v].nw);
      for (int i = 0; i < vecs[v].nw; i++)
        check({vecs[v].name, "_word"}, (i < got.size()) ? got[i] : 8'hxx, vecs[v].words[i]);
      check({vecs[v].name, "_idle"}, en_out, 0);
`ifdef HUFF_ENC_STATS_EN
      check({vecs[v].name, "_sym_cnt"}, sym_cnt, vecs[v].nsym);
      check({vecs[v].name, "_word_cnt"}, word_cnt, vecs[v].nw);
`endif
    end

    // Backpressure: 10 queued 2-bit symbols, downstream stalled
    conf_new();
    conf_wr(8'h20, 8'h02, 8'd2);
    conf_wr(8'h21, 8'h01, 8'd2);
    cycle();
    got.delete();
    d_req = 0; idx = 0;
    for (int k = 0; k < 12; k++) begin
      s_in = (idx % 2) ? 8'h21 : 8'h20; s_en = (idx < 10);
      cycle();
      if (acc_last) idx++;
    end
    check("bp_accepted", idx, 5);
    check("bp_s_req", s_req, 0);
    check("bp_word", d_out, 8'h99);
    hold = d_out;
    for (int k = 0; k < 3; k++) begin cycle(); check("bp_stable", d_out, hold); end
    d_req = 1; t = 0;
    while (idx < 10 && t < 100) begin
      s_in = (idx % 2) ? 8'h21 : 8'h20; s_en = 1;
      cycle(); t++;
      if (acc_last) idx++;
    end
    s_en = 0;
    check("bp_all_sent", idx, 10);
    flush_drain();
    check("bp_nwords", got.size(), 3);
    if (got.size() == 3) begin
      check("bp_w0", got[0], 8'h99);
      check("bp_w1", got[1], 8'h99);
      check("bp_w2", got[2], 8'h90);
    end

    // Errors: table miss, bad width, table overflow, clear by new_conf
    conf_new();
    conf_wr(8'h20, 8'h00, 8'd2);
    cycle();
    send(8'h99);
    check("miss_err", err, 1);
    check("miss_no_out", en_out, 0);
    conf_new();
    check("newconf_clr", err, 0);
    conf_wr(8'h10, 8'h01, 8'd0);
    check("badw_err", err, 1);
    conf_new();
    for (int k = 0; k < 16; k++) conf_wr(8'(k), 8'(k), 8'd4);
    check("full16_ok", err, 0);
    conf_wr(8'h77, 8'h01, 8'd1);
    check("ovf_err", err, 1);
    cycle();
    conf_new();
    check("ovf_clr", err, 0);

    // Randomized traffic
    conf_new();
    for (int k = 0; k < 6; k++)
      conf_wr(8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(1, 8)));
    cycle();
    for (int k = 0; k < 400; k++) begin
      s_in  = 8'($urandom_range(0, 19));
      s_en  = $urandom_range(0, 1);
      d_req = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      cycle();
    end
    s_en = 0; flush = 0;
    flush_drain();

    // Asynchronous reset mid-stream
    conf_new();
    conf_wr(8'h30, 8'h04, 8'd3);
    cycle();
    d_req = 0;
    send(8'h99);
    send(8'h30); send(8'h30); send(8'h30);
    check("pre_rst_word", d_out, 8'h92);
    check("pre_rst_en", en_out, 1);
    #2 rst = 0;
    #1;
    check("arst_s_req", s_req, 0);
    check("arst_d_out", d_out, 0);
    check("arst_en_out", en_out, 0);
    check("arst_err", err, 0);
`ifdef HUFF_ENC_STATS_EN
    check("arst_sym_cnt", sym_cnt, 0);
`endif
    model_reset();
    @(posedge clk); #3;
    rst = 1;
    cycle();
    check("post_rst_s_req", s_req, 1);
    d_req = 1;
    send(8'h30);
    check("post_rst_tbl_invalid", err, 1);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
